conv_line_sequencer: RTL and testbench
======================================

# conv_line_sequencer

Feeds the `convolution` block a three-row pixel window from a single raster stream of RGB565 pixels. It sits between the camera/frame-buffer pixel stream and `convolution`. It stores the two most recent complete lines in three rotating line RAMs and presents `{row v-2, row v-1, row v}` column-aligned. Its FSM handles frame start, line rotation and the two-line fill period, and it forwards centre-row coordinates so downstream addressing stays correct.

## Interface
- `HRES`, default 320: active pixels per line.
- `VRES`, default 240: active lines per frame.

- `clk_in`  input  1  system clock.
- `rst_in`  input  1  synchronous, active-low reset.
- `pixel_in`  input  16  RGB565 pixel, `[15:11]` R, `[10:5]` G, `[4:0]` B.
- `hcount_in`  input  11  pixel column.
- `vcount_in`  input  10  pixel row.
- `data_valid_in`  input  1  pixel/coordinates are valid this cycle.
- `data_out`  output  `[2:0][15:0]`  window column:
  - `[0]` is row v-2 (top).
  - `[1]` is row v-1 (centre).
  - `[2]` is row v (bottom, live).
- `hcount_out`  output  11  column of the `data_out` window.
- `vcount_out`  output  10  centre row, equal to `vcount_in - 1` of the producing pixel.
- `data_valid_out`  output  1  window valid; drives `convolution.data_valid_in`.
- `state_out`  output  2  current FSM state encoding.

## Operation
- **States:** `IDLE`=0, `FILL`=1, `STREAM`=2.
- **Reset:**
  - State goes to `IDLE`.
  - `wptr` (2-bit, values 0..2) = 0 and `lines_done` = 0.
  - All outputs are 0.
- **`IDLE`:** on `data_valid_in` with `hcount_in==0 && vcount_in==0`:
  - go to `FILL`, `wptr`=0, `lines_done`=0;
  - write the pixel.
- **Frame restart:** in any state, a valid pixel at (0,0) resets `wptr`, `lines_done` and state exactly as from `IDLE`. A restart mid-frame discards partial lines.
- **Write:** every valid pixel is written to `ram[wptr][hcount_in]`. Pixels with `hcount_in >= HRES` are not written.
- **Line rotation:**
  - Trigger: a valid pixel with `hcount_in==0` and `vcount_in != last_vcount`, not a frame restart.
  - `wptr` advances modulo 3 (2 wraps to 0) before that pixel is written.
  - `lines_done` saturates at 2.
  - When `lines_done` reaches 2 the state goes to `STREAM`.
- **Read:** in parallel with the write, read the other two buffers at address `hcount_in`:
  - `(wptr+1)%3` supplies row v-2;
  - `(wptr+2)%3` supplies row v-1.
- **Live row:** `pixel_in` is delayed to align with the RAM read data.
- **Output:**
  - In `STREAM`, each valid input yields one `data_valid_out` pulse carrying:
    - `hcount_out = hcount_in`;
    - `vcount_out = vcount_in - 1`.
  - In `FILL` and `IDLE`, `data_valid_out` stays 0. `data_out`, `hcount_out` and `vcount_out` hold their last values.
- **Boundary rows:** row 0 and row VRES-1 are never a centre row. This is the intended top/bottom crop.
- **Gaps:** `data_valid_in` low inserts bubbles. No state change and no writes occur during a bubble.

## Timing
- Latency is 2 cycles, valid in to valid out: 1 cycle RAM read, then 1 output register.
- `data_out[2]`, `hcount_out` and `vcount_out` pass through the same 2-stage pipe.
- Throughput is 1 pixel per cycle with no backpressure.
- Read and write never target the same RAM, so there is no read-during-write hazard.
- Reset asserted mid-line:
  - outputs read 0 on the first rising edge with `rst_in` low;
  - in-flight pipeline entries are dropped.
- First valid output of a frame: 2 cycles after pixel (0,2) is accepted, with `vcount_out`=1 and `hcount_out`=0.

## Configuration
- `CONV_SEQ_ERR_EN` defined adds output `error_out` (1 bit, sticky, reset 0). It is set on any valid pixel with any of:
  - `hcount_in >= HRES`;
  - `vcount_in >= VRES`;
  - a row change where `vcount_in` is not `last_vcount + 1` and is not a frame restart.
- `error_out` clears only on reset.
- Without the macro, the port and its logic are absent. Out-of-range pixels are silently dropped; nothing is written for them.

## Structure
- **`conv_pkg`** holds:
  - `pixel_t` (`logic [15:0]`);
  - `seq_state_t` enum `{IDLE, FILL, STREAM}`;
  - default `HRES` and `VRES` constants.
- **Sub-module `conv_line_ram`:** one write port, one read port, 1-cycle registered read, depth `HRES`, width 16. Three instances.

## Test plan
- **Reset:** hold `rst_in`=0 for 2 cycles → all outputs 0, `state_out`=0.
- **Ramp image:** feed a 10×4 frame with `HRES`=10 and `pixel_in = {vcount, hcount}` encoded. Required response:
  - no `data_valid_out` for rows 0–1;
  - for row 2, `data_out` = {row0, row1, row2} at each column, `vcount_out`=1, latency 2.
- **Rotation wrap:** feed 6 rows → at row 5, `data_out[0]` holds row 3 and `data_out[1]` holds row 4 (`wptr` has wrapped).
- **Bubbles:** deassert `data_valid_in` every other cycle in row 3 → outputs are identical to the dense case, just spread out.
- **Mid-frame restart:** inject (0,0) during row 2 → `state_out`=`FILL` and no valid output until the new row 2.
- **Errors (`CONV_SEQ_ERR_EN`):** `hcount_in`=15 with `HRES`=10 → `error_out`=1 and it stays high until reset.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and defaults for the three-row line sequencer feeding convolution.
package conv_pkg;

    typedef logic [15:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2
    } seq_state_t;

    localparam int HRES_DEF  = 320;
    localparam int VRES_DEF  = 240;
    localparam int NUM_LINES = 3;

    // Line-buffer pointer arithmetic modulo NUM_LINES (operands are 0..2).
    function automatic logic [1:0] ptr_add(input logic [1:0] p, input logic [1:0] k);
        logic [2:0] s;
        s = {1'b0, p} + {1'b0, k};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

endpackage

// File: rtl/conv_line_ram.sv
// Simple dual-port line buffer: one write port, one registered read port.
module conv_line_ram
    import conv_pkg::*;
#(
    parameter int DEPTH = HRES_DEF,
    parameter int AW    = 9
) (
    input  logic          clk_in,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  pixel_t        wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output pixel_t        rdata
);

    pixel_t mem [DEPTH];

    always_ff @(posedge clk_in) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/conv_line_sequencer.sv
// Rotating three-line buffer presenting {row v-2, row v-1, row v} column-aligned to convolution.
// Define CONV_SEQ_ERR_EN to add the sticky error_out port for out-of-range / non-sequential input.
module conv_line_sequencer
    import conv_pkg::*;
#(
    parameter int HRES = HRES_DEF,
    parameter int VRES = VRES_DEF
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [15:0]      pixel_in,
    input  logic [10:0]      hcount_in,
    input  logic [9:0]       vcount_in,
    input  logic             data_valid_in,
    output logic [2:0][15:0] data_out,
    output logic [10:0]      hcount_out,
    output logic [9:0]       vcount_out,
    output logic             data_valid_out,
    output logic [1:0]       state_out
`ifdef CONV_SEQ_ERR_EN
    ,
    output logic             error_out
`endif
);

    localparam int         AW     = (HRES > 1) ? $clog2(HRES) : 1;
    localparam int         STAGES = 2;
    localparam logic [10:0] HRES_L = 11'(HRES);
    localparam logic [9:0]  VRES_L = 10'(VRES);

    seq_state_t state, state_nx;
    logic [1:0] wptr, wptr_nx, lines_done, lines_nx;
    logic [9:0] last_vcount;
    logic       restart, row_chg, in_rng, wr_en, rd_en, out_en;

    logic [NUM_LINES-1:0][15:0] rd_data;
    logic [STAGES-1:0]          vld_pipe;
    logic [1:0]                 sel_p1;
    pixel_t                     pix_p1;
    logic [10:0]                hc_p1;
    logic [9:0]                 vc_p1;

    always_comb begin
        restart  = data_valid_in && hcount_in == '0 && vcount_in == '0;
        row_chg  = data_valid_in && !restart && state != IDLE &&
                   hcount_in == '0 && vcount_in != last_vcount;
        wptr_nx  = wptr;
        lines_nx = lines_done;
        state_nx = state;
        if (restart) begin
            wptr_nx  = '0;
            lines_nx = '0;
            state_nx = FILL;
        end else if (row_chg) begin
            // Rotate before writing so the new line lands in the oldest buffer.
            wptr_nx = ptr_add(wptr, 2'd1);
            if (lines_done != 2'd2) lines_nx = lines_done + 2'd1;
            if (lines_nx == 2'd2) state_nx = STREAM;
        end
        in_rng = hcount_in < HRES_L && vcount_in < VRES_L;
        wr_en  = data_valid_in && in_rng && state_nx != IDLE;
        rd_en  = data_valid_in && in_rng;
        out_en = data_valid_in && state_nx == STREAM;
    end

    // The buffer being written is never read, so no read-during-write case exists.
    for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
        conv_line_ram #(.DEPTH(HRES), .AW(AW)) u_ram (
            .clk_in (clk_in),
            .we     (wr_en && wptr_nx == 2'(i)),
            .waddr  (hcount_in[AW-1:0]),
            .wdata  (pixel_in),
            .re     (rd_en && wptr_nx != 2'(i)),
            .raddr  (hcount_in[AW-1:0]),
            .rdata  (rd_data[i])
        );
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state       <= IDLE;
            wptr        <= '0;
            lines_done  <= '0;
            last_vcount <= '0;
            vld_pipe    <= '0;
            sel_p1      <= '0;
            pix_p1      <= '0;
            hc_p1       <= '0;
            vc_p1       <= '0;
            data_out    <= '0;
            hcount_out  <= '0;
            vcount_out  <= '0;
        end else begin
            if (data_valid_in) begin
                state       <= state_nx;
                wptr        <= wptr_nx;
                lines_done  <= lines_nx;
                last_vcount <= vcount_in;
            end
            vld_pipe <= {vld_pipe[STAGES-2:0], out_en};
            if (out_en) begin
                sel_p1 <= wptr_nx;
                pix_p1 <= pixel_in;
                hc_p1  <= hcount_in;
                vc_p1  <= vcount_in - 10'd1;
            end
            if (vld_pipe[0]) begin
                data_out[0] <= rd_data[ptr_add(sel_p1, 2'd1)];
                data_out[1] <= rd_data[ptr_add(sel_p1, 2'd2)];
                data_out[2] <= pix_p1;
                hcount_out  <= hc_p1;
                vcount_out  <= vc_p1;
            end
        end
    end

    assign data_valid_out = vld_pipe[STAGES-1];
    assign state_out      = state;

`ifdef CONV_SEQ_ERR_EN
    logic seq_err;

    always_comb begin
        seq_err = data_valid_in &&
                  (hcount_in >= HRES_L || vcount_in >= VRES_L ||
                   (hcount_in == '0 && !restart && vcount_in != last_vcount &&
                    vcount_in != last_vcount + 10'd1));
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in)      error_out <= 1'b0;
        else if (seq_err) error_out <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_conv_line_sequencer.sv
// Scoreboard bench for conv_line_sequencer with HRES=10; pixels encode {vcount, hcount}.
module tb_conv_line_sequencer;

    localparam int H = 10;
    localparam int V = 6;

    typedef struct {
        logic [2:0][15:0] d;
        int               hc;
        int               vc;
        int               due;
    } exp_t;

    typedef struct {
        logic       vld;
        int         h;
        int         v;
        logic [1:0] st;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [15:0]      pixel;
    logic [10:0]      hcount;
    logic [9:0]       vcount;
    logic             valid;
    logic [2:0][15:0] data_out;
    logic [10:0]      hcount_out;
    logic [9:0]       vcount_out;
    logic             data_valid_out;
    logic [1:0]       state_out;
`ifdef CONV_SEQ_ERR_EN
    logic             error_out;
`endif

    int               cyc = 0;
    int               n_chk = 0;
    int               n_pass = 0;
    exp_t             sb[$];
    exp_t             ce;
    logic [2:0][15:0] last_d;
    bit               m_active;
    int               m_rows;
    int               m_lastv;
    vec_t             tbl [9];

    conv_line_sequencer #(.HRES(H), .VRES(V)) dut (
        .clk_in         (clk),
        .rst_in         (rst_n),
        .pixel_in       (pixel),
        .hcount_in      (hcount),
        .vcount_in      (vcount),
        .data_valid_in  (valid),
        .data_out       (data_out),
        .hcount_out     (hcount_out),
        .vcount_out     (vcount_out),
        .data_valid_out (data_valid_out),
        .state_out      (state_out)
`ifdef CONV_SEQ_ERR_EN
        ,
        .error_out      (error_out)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] pix(int v, int h);
        return {8'(v), 8'(h)};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, want);
    endtask

    // Drives one cycle of input; the frame model decides whether a window is due.
    task automatic drive(bit vld, int h, int v);
        exp_t e;
        @(negedge clk);
        valid  = vld;
        hcount = 11'(h);
        vcount = 10'(v);
        pixel  = pix(v, h);
        if (vld) begin
            if (h == 0 && v == 0) begin
                m_active = 1;
                m_rows   = 0;
            end else if (m_active && h == 0 && v != m_lastv && m_rows < 2) begin
                m_rows++;
            end
            m_lastv = v;
            if (m_active && m_rows == 2) begin
                e.d[0] = pix(v - 2, h);
                e.d[1] = pix(v - 1, h);
                e.d[2] = pix(v, h);
                e.hc   = h;
                e.vc   = v - 1;
                e.due  = cyc + 2;
                sb.push_back(e);
            end
        end
    endtask

    task automatic row(int v, int h0, int h1, bit bubbles);
        for (int h = h0; h <= h1; h++) begin
            drive(1'b1, h, v);
            if (bubbles) drive(1'b0, h, v);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && data_valid_out) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 64'(data_valid_out), 64'd0);
            end else begin
                ce = sb.pop_front();
                chk("data", 64'(data_out), 64'(ce.d));
                chk("hcount", 64'(hcount_out), 64'(ce.hc));
                chk("vcount", 64'(vcount_out), 64'(ce.vc));
                chk("latency", 64'(cyc), 64'(ce.due));
                last_d = ce.d;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: cyc=%0d want finish", cyc);
        $fatal(1);
    end

    initial begin
        tbl = '{
            '{1'b1, 1, 0, 2'd0},
            '{1'b1, 0, 0, 2'd1},
            '{1'b1, 1, 0, 2'd1},
            '{1'b0, 0, 1, 2'd1},
            '{1'b1, 0, 1, 2'd1},
            '{1'b1, 0, 2, 2'd2},
            '{1'b1, 0, 3, 2'd2},
            '{1'b1, 0, 0, 2'd1},
            '{1'b1, 0, 1, 2'd1}
        };
        valid = 0; pixel = '0; hcount = '0; vcount = '0;
        m_active = 0; m_rows = 0; m_lastv = 0; last_d = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(data_valid_out), 64'd0);
        chk("rst_data", 64'(data_out), 64'd0);
        chk("rst_hcount", 64'(hcount_out), 64'd0);
        chk("rst_vcount", 64'(vcount_out), 64'd0);
        chk("rst_state", 64'(state_out), 64'd0);
`ifdef CONV_SEQ_ERR_EN
        chk("rst_error", 64'(error_out), 64'd0);
`endif
        @(negedge clk) rst_n = 1'b1;

        // State walk: IDLE ignores non-origin pixels, fill, stream, bubble, restart.
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].vld, tbl[i].h, tbl[i].v);
            @(posedge clk);
            #1;
            chk($sformatf("state_vec%0d", i), 64'(state_out), 64'(tbl[i].st));
        end

        // Full 6-row frame (pointer wraps at row 3/5), bubbles through row 3.
        for (int v = 0; v < V; v++) row(v, 0, H - 1, v == 3);

        // Mid-frame restart during row 2.
        row(0, 0, H - 1, 0);
        row(1, 0, H - 1, 0);
        row(2, 0, 4, 0);
        drive(1'b1, 0, 0);
        @(posedge clk);
        #1;
        chk("restart_state", 64'(state_out), 64'd1);
        row(0, 1, H - 1, 0);
        row(1, 0, H - 1, 0);
        drive(1'b0, 0, 1);
        @(negedge clk);
        chk("fill_state", 64'(state_out), 64'd1);
        chk("fill_hold_data", 64'(data_out), 64'(last_d));
        row(2, 0, H - 1, 0);
        row(3, 0, H - 1, 0);
        drive(1'b0, 0, 0);
        for (int k = 0; k < 8 && sb.size() != 0; k++) @(negedge clk);
        chk("sb_drain", 64'(sb.size()), 64'd0);

        // Reset asserted mid-line with windows in flight.
        row(0, 0, H - 1, 0);
        row(1, 0, H - 1, 0);
        row(2, 0, 3, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        valid = 1'b0;
        sb.delete();
        m_active = 0;
        m_rows   = 0;
        @(posedge clk);
        #1;
        chk("midrst_valid", 64'(data_valid_out), 64'd0);
        chk("midrst_data", 64'(data_out), 64'd0);
        chk("midrst_hcount", 64'(hcount_out), 64'd0);
        chk("midrst_vcount", 64'(vcount_out), 64'd0);
        chk("midrst_state", 64'(state_out), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_state", 64'(state_out), 64'd0);

`ifdef CONV_SEQ_ERR_EN
        drive(1'b1, 15, 0);
        @(posedge clk);
        #1;
        chk("err_set", 64'(error_out), 64'd1);
        drive(1'b0, 0, 0);
        repeat (3) @(negedge clk);
        chk("err_sticky", 64'(error_out), 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("err_clear", 64'(error_out), 64'd0);
        @(negedge clk) rst_n = 1'b1;
`endif

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
